// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program-counter generator for RV32I/RV64I pipelines.
// Presents the fetch PC under a valid/ready handshake. The next PC is chosen
// with fixed priority: trap vector, then branch/jump redirect, then PC+STEP.
// A BOOT/RUN/HALT state machine provides halt and resume control.
//
// Optional build macro PC_UNIT_MISALIGN_CHK_EN:
//   defined   - misaligned redirect targets are dropped, and misalign_fault
//               pulses for one cycle.
//   undefined - redirect targets are loaded with bits [1:0] cleared, and
//               misalign_fault is tied to 0.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 'h80000000,
  parameter int              STEP         = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_step,
  output logic            pc_valid,
  output logic            halted,
  output logic            misalign_fault
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            halted_q;

  // Whether a redirect may be taken, and the address it would load.
  logic            redirect_ok;
  logic [XLEN-1:0] redirect_pc;

  // Sequential address. The adder wraps naturally modulo 2^XLEN.
  assign pc_plus_step = pc_q + XLEN'(STEP);

`ifdef PC_UNIT_MISALIGN_CHK_EN
  logic misalign_fault_q;

  // A misaligned target is refused outright instead of being rounded down.
  assign redirect_ok    = (redirect_target[1:0] == 2'b00);
  assign redirect_pc    = redirect_target;
  assign misalign_fault = misalign_fault_q;
`else
  // Targets are always accepted, with the low two bits cleared.
  assign redirect_ok    = 1'b1;
  assign redirect_pc    = redirect_target & ~XLEN'(3);
  assign misalign_fault = 1'b0;
`endif

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;

  // FSM: state, PC and the registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
`ifdef PC_UNIT_MISALIGN_CHK_EN
      misalign_fault_q <= 1'b0;
`endif
    end else begin
`ifdef PC_UNIT_MISALIGN_CHK_EN
      misalign_fault_q <= 1'b0;
`endif
      case (state_q)
        // Let the reset vector settle for one cycle, then start issuing it.
        BOOT: begin
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
          halted_q   <= 1'b0;
        end

        RUN: begin
          if (trap_valid) begin
            pc_q       <= trap_vector;
            pc_valid_q <= 1'b1;
          end else if (redirect_valid && redirect_ok) begin
            // The squashed PC is dropped; the target is presented next.
            pc_q       <= redirect_pc;
            pc_valid_q <= 1'b1;
          end else begin
`ifdef PC_UNIT_MISALIGN_CHK_EN
            if (redirect_valid) begin
              misalign_fault_q <= 1'b1;
            end
`endif
            if (halt_req) begin
              // Keep the PC so fetch resumes exactly where it stopped.
              state_q    <= HALT;
              pc_valid_q <= 1'b0;
              halted_q   <= 1'b1;
            end else if (pc_valid_q && fetch_ready) begin
              pc_q <= pc_plus_step;
            end
          end
        end

        HALT: begin
          if (trap_valid) begin
            // A trap wakes the core at the handler address.
            pc_q       <= trap_vector;
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
          end else begin
            if (redirect_valid) begin
              if (redirect_ok) begin
                pc_q <= redirect_pc;
              end
`ifdef PC_UNIT_MISALIGN_CHK_EN
              else begin
                misalign_fault_q <= 1'b1;
              end
`endif
            end
            // If halt and resume are requested together, resume wins.
            if (resume_req) begin
              state_q    <= RUN;
              pc_valid_q <= 1'b1;
              halted_q   <= 1'b0;
            end
          end
        end

        default: begin
          state_q    <= BOOT;
          pc_valid_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
